// File: rtl/frame_averager.sv
// Frame averager: sums 2^LOG2_AVG equal-length AXI-Stream frames sample by sample,
// then streams out the floor-rounded per-sample average as one frame.
module frame_averager #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DATA_WIDTH             = 16,
    parameter int FRAME_LEN              = 1024,
    parameter int LOG2_AVG               = 3
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  s00_axis_tready,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    input  logic                                  restart,
    output logic                                  frame_err,
    output logic [8:0]                            frames_acc
);
    localparam int ACC_WIDTH = DATA_WIDTH + LOG2_AVG;
    localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [8:0]       N_FRAMES = 9'(1 << LOG2_AVG);

    typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [IDX_W-1:0]              rd_idx_q, rd_idx_d;
    logic [8:0]                    frames_q, frames_d;
    logic                          err_q, err_d;
    logic                          drop_q, drop_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic signed [DATA_WIDTH-1:0]  data_q, data_d;
    logic                          strb_q;

    logic signed [ACC_WIDTH-1:0]   acc_mem [FRAME_LEN];
    logic                          mem_we;
    logic signed [ACC_WIDTH-1:0]   mem_wdata;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [ACC_WIDTH-1:0]   sample_ext;
    logic signed [ACC_WIDTH-1:0]   acc_rd;
    logic                          beat;
    logic                          unused_inputs;

    assign sample          = s00_axis_tdata[DATA_WIDTH-1:0];
    assign sample_ext      = ACC_WIDTH'(sample);
    assign acc_rd          = acc_mem[rd_idx_q];
    assign s00_axis_tready = s00_axis_aresetn && (state_q == ST_ACCUM);
    assign beat            = s00_axis_tvalid && s00_axis_tready;
    assign unused_inputs   = ^{s00_axis_tstrb, s00_axis_tdata};

    assign m00_axis_tvalid = valid_q;
    assign m00_axis_tlast  = last_q;
    assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(data_q);
    assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){strb_q}};
    assign frame_err       = err_q;
    assign frames_acc      = frames_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        frames_d  = frames_q;
        err_d     = err_q;
        drop_d    = drop_q;
        valid_d   = valid_q;
        last_d    = last_q;
        data_d    = data_q;
        mem_we    = 1'b0;
        mem_wdata = (frames_q == 9'd0) ? sample_ext : acc_mem[idx_q] + sample_ext;

        if (restart) begin
            state_d  = ST_ACCUM;
            idx_d    = '0;
            frames_d = '0;
            err_d    = 1'b0;
            drop_d   = 1'b0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (beat && drop_q) begin
                        // Resynchronising after a missing tlast: discard up to and including the next tlast.
                        if (s00_axis_tlast) begin
                            drop_d = 1'b0;
                            idx_d  = '0;
                        end
                    end else if (beat) begin
                        mem_we = 1'b1;
                        if (idx_q == LAST_IDX && s00_axis_tlast) begin
                            idx_d    = '0;
                            frames_d = frames_q + 9'd1;
                            if (frames_q + 9'd1 == N_FRAMES) begin
                                state_d  = ST_DRAIN;
                                rd_idx_d = '0;
                            end
                        end else if (idx_q == LAST_IDX || s00_axis_tlast) begin
                            err_d    = 1'b1;
                            frames_d = '0;
                            idx_d    = '0;
                            drop_d   = !s00_axis_tlast;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (valid_q && m00_axis_tready && last_q) begin
                        state_d  = ST_ACCUM;
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                        frames_d = '0;
                        idx_d    = '0;
                    end else if (!valid_q || m00_axis_tready) begin
                        valid_d  = 1'b1;
                        data_d   = DATA_WIDTH'(acc_rd >>> LOG2_AVG);
                        last_d   = (rd_idx_q == LAST_IDX);
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q  <= ST_ACCUM;
            idx_q    <= '0;
            rd_idx_q <= '0;
            frames_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            strb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rd_idx_q <= rd_idx_d;
            frames_q <= frames_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            strb_q   <= 1'b1;
        end
    end

    // Accumulator storage is deliberately left unreset; a fresh set always overwrites it.
    always_ff @(posedge s00_axis_aclk) begin
        if (mem_we) begin
            acc_mem[idx_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_frame_averager.sv
// Randomised self-checking bench for frame_averager (FRAME_LEN=8, N=4 frames).
module tb_frame_averager;
    localparam int DW   = 16;
    localparam int FL   = 8;
    localparam int LA   = 2;
    localparam int NAVG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tstrb = '0;
    logic        s_tready;
    logic        m_tready = 1'b0;
    logic        m_tvalid;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        restart = 1'b0;
    logic        frame_err;
    logic [8:0]  frames_acc;

    int checks = 0;
    int errors = 0;
    int frame_buf [FL];
    int sums [FL];
    int nfr = 0;
    bit merr = 1'b0;

    frame_averager #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .DATA_WIDTH(DW),
        .FRAME_LEN(FL),
        .LOG2_AVG(LA)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tstrb(s_tstrb),
        .s00_axis_tready(s_tready),
        .m00_axis_tready(m_tready),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tstrb(m_tstrb),
        .restart(restart),
        .frame_err(frame_err),
        .frames_acc(frames_acc)
    );

    always #5 clk = ~clk;

    // Reference average: mathematical floor of sum / N.
    function automatic int floor_avg(input int s);
        int r;
        r = ((s % NAVG) + NAVG) % NAVG;
        return (s - r) / NAVG;
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic send_frame(input int len, input bit with_last);
        logic [31:0] r;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL s_tready_before_frame got %b want 1", s_tready);
        end
        for (int i = 0; i < len; i++) begin
            r        = $urandom();
            s_tvalid = 1'b1;
            s_tdata  = {r[31:16], 16'(frame_buf[i])};
            s_tstrb  = r[3:0];
            s_tlast  = with_last && (i == len - 1);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (with_last && len == FL) begin
            for (int i = 0; i < FL; i++) sums[i] = (nfr == 0) ? frame_buf[i] : sums[i] + frame_buf[i];
            nfr++;
        end else if (with_last || len >= FL) begin
            merr = 1'b1;
            nfr  = 0;
        end
        checks++;
        if (frames_acc !== 9'(nfr)) begin
            errors++;
            $display("[TB] FAIL frames_acc got %0d want %0d", frames_acc, nfr);
        end
        checks++;
        if (frame_err !== merr) begin
            errors++;
            $display("[TB] FAIL frame_err got %b want %b", frame_err, merr);
        end
    endtask

    task automatic send_random_set();
        for (int f = 0; f < NAVG; f++) begin
            for (int i = 0; i < FL; i++) frame_buf[i] = rand_sample();
            send_frame(FL, 1'b1);
        end
    endtask

    task automatic drain(input bit rand_ready, input int stop_after);
        int k, cyc, first_cyc;
        bit stalled;
        logic [31:0] pdata, expw;
        logic plast, explast;
        k = 0; cyc = 0; first_cyc = -1; stalled = 1'b0;
        pdata = '0; plast = 1'b0;
        while (k < stop_after && cyc < 400) begin
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== pdata || m_tlast !== plast) begin
                    errors++;
                    $display("[TB] FAIL stall_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             m_tvalid, m_tdata, m_tlast, pdata, plast);
                end
            end
            stalled = 1'b0;
            if (m_tvalid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                checks++;
                if (s_tready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL s_tready_in_drain got %b want 0", s_tready);
                end
                checks++;
                if (m_tstrb !== 4'hF) begin
                    errors++;
                    $display("[TB] FAIL m_tstrb got %h want f", m_tstrb);
                end
                if (m_tready) begin
                    expw    = floor_avg(sums[k]);
                    explast = (k == FL - 1);
                    checks++;
                    if (m_tdata !== expw) begin
                        errors++;
                        $display("[TB] FAIL out_word%0d got %h want %h", k, m_tdata, expw);
                    end
                    checks++;
                    if (m_tlast !== explast) begin
                        errors++;
                        $display("[TB] FAIL out_tlast%0d got %b want %b", k, m_tlast, explast);
                    end
                    k++;
                end else begin
                    stalled = 1'b1;
                    pdata   = m_tdata;
                    plast   = m_tlast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (k != stop_after) begin
            errors++;
            $display("[TB] FAIL drain_timeout got %0d words want %0d", k, stop_after);
        end
        checks++;
        if (first_cyc < 0 || first_cyc > 3) begin
            errors++;
            $display("[TB] FAIL first_valid_latency got %0d want <=3", first_cyc);
        end
        if (stop_after == FL) begin
            nfr = 0;
            checks++;
            if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || frames_acc !== 9'd0) begin
                errors++;
                $display("[TB] FAIL post_drain got rdy=%b v=%b fa=%0d want rdy=1 v=0 fa=0",
                         s_tready, m_tvalid, frames_acc);
            end
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        nfr  = 0;
        merr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake got rdy=%b v=%b l=%b want 0 0 0", s_tready, m_tvalid, m_tlast);
        end
        checks++;
        if (m_tdata !== 32'd0 || m_tstrb !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got d=%h s=%h want 0 0", m_tdata, m_tstrb);
        end
        checks++;
        if (frame_err !== 1'b0 || frames_acc !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_status got err=%b fa=%0d want 0 0", frame_err, frames_acc);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_reset got %b want 1", s_tready);
        end
        @(posedge clk); #1;
        nfr = 0; merr = 1'b0;
    endtask

    task automatic test_constant();
        for (int i = 0; i < FL; i++) frame_buf[i] = 100;
        for (int f = 0; f < NAVG; f++) send_frame(FL, 1'b1);
        drain(1'b0, FL);
    endtask

    task automatic test_rounding();
        for (int f = 0; f < NAVG; f++) begin
            for (int i = 0; i < FL; i++) frame_buf[i] = i + f;
            send_frame(FL, 1'b1);
        end
        drain(1'b0, FL);
        for (int f = 0; f < NAVG; f++) begin
            for (int i = 0; i < FL; i++) frame_buf[i] = (f < 3) ? -1 : -2;
            send_frame(FL, 1'b1);
        end
        drain(1'b0, FL);
    endtask

    task automatic test_extremes();
        for (int i = 0; i < FL; i++) frame_buf[i] = 32767;
        for (int f = 0; f < NAVG; f++) send_frame(FL, 1'b1);
        drain(1'b1, FL);
        for (int i = 0; i < FL; i++) frame_buf[i] = -32768;
        for (int f = 0; f < NAVG; f++) send_frame(FL, 1'b1);
        drain(1'b1, FL);
    endtask

    task automatic test_length_error();
        for (int i = 0; i < FL; i++) frame_buf[i] = rand_sample();
        send_frame(FL, 1'b1);
        send_frame(5, 1'b1);
        send_random_set();
        drain(1'b1, FL);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky got %b want 1", frame_err);
        end
        pulse_restart();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared got %b want 0", frame_err);
        end
    endtask

    task automatic test_missing_tlast();
        for (int i = 0; i < FL; i++) frame_buf[i] = rand_sample();
        send_frame(FL, 1'b0);
        send_frame(3, 1'b1);
        send_random_set();
        drain(1'b0, FL);
        pulse_restart();
    endtask

    task automatic test_restart();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FL; i++) frame_buf[i] = rand_sample();
            send_frame(FL, 1'b1);
        end
        send_frame(3, 1'b0);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = $urandom();
        pulse_restart();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        checks++;
        if (frames_acc !== 9'd0 || frame_err !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_accum got fa=%0d err=%b v=%b want 0 0 0", frames_acc, frame_err, m_tvalid);
        end
        send_random_set();
        drain(1'b0, FL);
        send_random_set();
        drain(1'b0, 2);
        pulse_restart();
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || frames_acc !== 9'd0) begin
            errors++;
            $display("[TB] FAIL restart_drain got v=%b rdy=%b fa=%0d want 0 1 0", m_tvalid, s_tready, frames_acc);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            send_random_set();
            drain(1'b1, FL);
        end
    endtask

    task automatic test_reset_mid_drain();
        send_random_set();
        drain(1'b0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'd0 || m_tlast !== 1'b0 || s_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_drain_reset got v=%b d=%h l=%b rdy=%b want 0 0 0 0",
                     m_tvalid, m_tdata, m_tlast, s_tready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        nfr = 0; merr = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1 || frames_acc !== 9'd0) begin
            errors++;
            $display("[TB] FAIL after_mid_reset got rdy=%b fa=%0d want 1 0", s_tready, frames_acc);
        end
        @(posedge clk); #1;
        send_random_set();
        drain(1'b0, FL);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_rounding();
        test_extremes();
        test_length_error();
        test_missing_tlast();
        test_restart();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
